// File: rtl/opregister_sequencer.sv
// Drives an opregister through one load and a full sweep of operations,
// collecting every operation result into a packed vector per run.
module opregister_sequencer #(
    parameter int DATA_WIDTH  = 4,
    parameter int NUM_OPS     = 4,
    parameter int OPSEL_WIDTH = 2
) (
    input  logic                           i_w_clk,
    input  logic                           i_w_reset,
    input  logic                           i_w_start,
    input  logic [DATA_WIDTH-1:0]          i_w_operand,
    input  logic [DATA_WIDTH-1:0]          i_w_result,
    output logic [DATA_WIDTH-1:0]          o_w_data,
    output logic                           o_w_we,
    output logic                           o_w_oe,
    output logic [OPSEL_WIDTH-1:0]         o_w_opsel,
    output logic                           o_w_busy,
    output logic [NUM_OPS*DATA_WIDTH-1:0]  o_w_results,
    output logic                           o_w_valid,
    output logic [7:0]                     o_w_runs
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SELECT,
        S_ENABLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [OPSEL_WIDTH-1:0] LAST_OP = OPSEL_WIDTH'(NUM_OPS - 1);

    state_t                          state_q, state_d;
    logic [OPSEL_WIDTH-1:0]          k_q, k_d;
    logic [DATA_WIDTH-1:0]           data_q, data_d;
    logic [NUM_OPS*DATA_WIDTH-1:0]   results_q, results_d;
    logic [7:0]                      runs_q, runs_d;
    logic                            we_q, we_d;
    logic                            oe_q, oe_d;
    logic [OPSEL_WIDTH-1:0]          opsel_q, opsel_d;
    logic                            busy_q, busy_d;
    logic                            valid_q, valid_d;

    // Next state, datapath updates, and outputs decoded from the next state
    // so every output comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        data_d    = data_q;
        results_d = results_q;
        runs_d    = runs_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_w_start) begin
                    data_d    = i_w_operand;
                    results_d = '0;
                    k_d       = '0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD:   state_d = S_SELECT;
            S_SELECT: state_d = S_ENABLE;
            S_ENABLE: state_d = S_SAMPLE;
            S_SAMPLE: begin
                for (int s = 0; s < NUM_OPS; s++) begin
                    if (k_q == OPSEL_WIDTH'(s)) begin
                        results_d[s*DATA_WIDTH +: DATA_WIDTH] = i_w_result;
                    end
                end
                if (k_q == LAST_OP) begin
                    runs_d  = runs_q + 8'd1;
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_SELECT;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        we_d    = (state_d == S_LOAD);
        oe_d    = (state_d == S_ENABLE) || (state_d == S_SAMPLE);
        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_DONE);
        if (state_d == S_LOAD) begin
            opsel_d = '0;
        end else if (state_d == S_SELECT) begin
            opsel_d = k_d;
        end else begin
            opsel_d = opsel_q;
        end
    end

    // State and registered outputs; reset aborts any run and clears all.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            data_q    <= '0;
            results_q <= '0;
            runs_q    <= '0;
            we_q      <= 1'b0;
            oe_q      <= 1'b0;
            opsel_q   <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            data_q    <= data_d;
            results_q <= results_d;
            runs_q    <= runs_d;
            we_q      <= we_d;
            oe_q      <= oe_d;
            opsel_q   <= opsel_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    assign o_w_data    = data_q;
    assign o_w_we      = we_q;
    assign o_w_oe      = oe_q;
    assign o_w_opsel   = opsel_q;
    assign o_w_busy    = busy_q;
    assign o_w_results = results_q;
    assign o_w_valid   = valid_q;
    assign o_w_runs    = runs_q;

endmodule

// File: tb/tb_opregister_sequencer.sv
// Directed bench for opregister_sequencer with a stubbed opregister that
// returns (data + opsel) mod 16 while output-enable is high.
module tb_opregister_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  operand;
    logic [3:0]  result;
    logic [3:0]  data;
    logic        we;
    logic        oe;
    logic [1:0]  opsel;
    logic        busy;
    logic [15:0] results;
    logic        valid;
    logic [7:0]  runs;

    int vectors;
    int miscompares;

    opregister_sequencer dut (
        .i_w_clk     (clk),
        .i_w_reset   (reset),
        .i_w_start   (start),
        .i_w_operand (operand),
        .i_w_result  (result),
        .o_w_data    (data),
        .o_w_we      (we),
        .o_w_oe      (oe),
        .o_w_opsel   (opsel),
        .o_w_busy    (busy),
        .o_w_results (results),
        .o_w_valid   (valid),
        .o_w_runs    (runs)
    );

    assign result = oe ? 4'(data + {2'b00, opsel}) : 4'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".data"}, 32'(data), 32'h0);
        chk({tag, ".we"}, 32'(we), 32'h0);
        chk({tag, ".oe"}, 32'(oe), 32'h0);
        chk({tag, ".opsel"}, 32'(opsel), 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
        chk({tag, ".results"}, 32'(results), 32'h0);
        chk({tag, ".valid"}, 32'(valid), 32'h0);
        chk({tag, ".runs"}, 32'(runs), 32'h0);
    endtask

    function automatic logic [15:0] exp_res(input logic [3:0] op);
        logic [15:0] r;
        for (int s = 0; s < 4; s++) r[s*4 +: 4] = 4'(op + 4'(s));
        return r;
    endfunction

    // Starts a run in the current cycle (cycle 0) and checks every cycle
    // through cycle 15. poke_cyc injects an ignored start; abort_cyc
    // asserts reset in that cycle and returns after checking the clear.
    task automatic do_run(input logic [3:0] op, input logic [15:0] exp_r,
                          input logic [7:0] exp_runs, input int poke_cyc,
                          input int abort_cyc);
        int ex_opsel;
        logic ex_oe;
        start   = 1'b1;
        operand = op;
        step();
        start   = 1'b0;
        operand = ~op;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (cyc == poke_cyc + 1) start = 1'b0;
            if (cyc == 1) ex_opsel = 0;
            else if (cyc == 14) ex_opsel = 3;
            else ex_opsel = (cyc - 2) / 3;
            ex_oe = (cyc >= 2) && (cyc <= 13) && (((cyc - 2) % 3) != 0);
            chk($sformatf("c%0d.we", cyc), 32'(we), 32'(cyc == 1));
            chk($sformatf("c%0d.oe", cyc), 32'(oe), 32'(ex_oe));
            chk($sformatf("c%0d.opsel", cyc), 32'(opsel), 32'(ex_opsel));
            chk($sformatf("c%0d.busy", cyc), 32'(busy), 32'h1);
            chk($sformatf("c%0d.valid", cyc), 32'(valid), 32'(cyc == 14));
            chk($sformatf("c%0d.data", cyc), 32'(data), 32'(op));
            if (cyc == 1) chk("c1.results_clear", 32'(results), 32'h0);
            if (cyc == 14) begin
                chk("c14.results", 32'(results), 32'(exp_r));
                chk("c14.runs", 32'(runs), 32'(exp_runs));
            end
            if (cyc == poke_cyc) begin
                start   = 1'b1;
                operand = 4'hA;
            end
            if (cyc == abort_cyc) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                chk_zero("abort");
                return;
            end
            step();
        end
        chk("c15.busy", 32'(busy), 32'h0);
        chk("c15.valid", 32'(valid), 32'h0);
        chk("c15.results_hold", 32'(results), 32'(exp_r));
        chk("c15.data_hold", 32'(data), 32'(op));
        chk("c15.opsel_hold", 32'(opsel), 32'h3);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b1;
        operand     = 4'h9;
        step();
        step();
        chk_zero("reset_with_start");
        start = 1'b0;
        reset = 1'b0;
        step();
        chk_zero("idle");

        do_run(4'h5, 16'h8765, 8'd1, 0, 0);
        do_run(4'hF, 16'h210F, 8'd2, 0, 0);
        do_run(4'h3, 16'h6543, 8'd3, 5, 0);
        step();
        chk("after_poke.valid", 32'(valid), 32'h0);
        chk("after_poke.busy", 32'(busy), 32'h0);
        chk("after_poke.runs", 32'(runs), 32'd3);

        do_run(4'h7, 16'hA987, 8'd4, 0, 7);
        step();
        chk("abort_c9.valid", 32'(valid), 32'h0);
        chk("abort_c9.runs", 32'(runs), 32'h0);
        step();
        chk("abort_c10.busy", 32'(busy), 32'h0);
        do_run(4'h1, 16'h4321, 8'd1, 0, 0);

        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk_zero("reset_before_wrap");
        for (int i = 1; i <= 256; i++) begin
            do_run(4'(i), exp_res(4'(i)), 8'(i), 0, 0);
        end
        chk("wrap.runs", 32'(runs), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
